// File: rtl/painterengine_gpu_block_reader_pkg.sv
// Shared definitions for the block reader: FSM state codes and AXI constants.
package painterengine_gpu_block_reader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StAddr  = 3'd2,
    StData  = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5,
    StDrain = 3'd6
  } state_e;

  localparam logic [1:0]  AxiRespOkay  = 2'b00;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam int unsigned PageBytes    = 4096;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Beats for the next AR: min(remaining, MAX_BURST, words left in the current 4 KB page).
module painterengine_gpu_burst_calc
  import painterengine_gpu_block_reader_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [15:0] remaining_i,
  input  logic [11:0] addr_lo_i,
  output logic [8:0]  beats_o
);

  localparam logic [15:0] MaxBurst = 16'(MAX_BURST);

  logic [15:0] room;
  logic [8:0]  min_rb;

  always_comb begin
    room    = 16'((PageBytes - 32'(addr_lo_i)) >> 2);
    // MAX_BURST <= 256, so the first minimum always fits in 9 bits
    min_rb  = (remaining_i < MaxBurst) ? remaining_i[8:0] : MaxBurst[8:0];
    beats_o = ({7'd0, min_rb} < room) ? min_rb : room[8:0];
  end

endmodule

// File: rtl/painterengine_gpu_block_reader.sv
// Reader command responder: fetches a pixel run over AXI4 read and streams it into a pixel FIFO.
module painterengine_gpu_block_reader
  import painterengine_gpu_block_reader_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned MAX_LENGTH = 64
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_run,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_araddr,
  output logic [7:0]  o_wire_arlen,
  output logic        o_wire_arvalid,
  input  logic        i_wire_arready,
  input  logic [31:0] i_wire_rdata,
  input  logic [1:0]  i_wire_rresp,
  input  logic        i_wire_rlast,
  input  logic        i_wire_rvalid,
  output logic        o_wire_rready,
  output logic [31:0] o_wire_fifo_wdata,
  output logic        o_wire_fifo_wen,
  input  logic        i_wire_fifo_full,
  output logic [31:0] o_wire_state
);

  state_e      state_q;
  logic [31:0] addr_q, length_q, araddr_q;
  logic [15:0] remaining_q;
  logic [8:0]  beats_q, count_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q, done_q, error_q, drain_err_q;

  logic        r_hs, last_beat, beat_bad;
  logic [15:0] rem_after, calc_rem;
  logic [31:0] addr_after;
  logic [11:0] calc_addr_lo;
  logic [8:0]  calc_beats;

  assign rem_after    = remaining_q - {7'd0, beats_q};
  assign addr_after   = addr_q + {21'd0, beats_q, 2'b00};
  // In DATA the calculator looks ahead to the burst that follows the current one
  assign calc_rem     = (state_q == StData) ? rem_after : remaining_q;
  assign calc_addr_lo = (state_q == StData) ? addr_after[11:0] : addr_q[11:0];

  painterengine_gpu_burst_calc #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .remaining_i(calc_rem),
    .addr_lo_i  (calc_addr_lo),
    .beats_o    (calc_beats)
  );

  assign o_wire_rready     = (state_q == StDrain) | ((state_q == StData) & ~i_wire_fifo_full);
  assign r_hs              = i_wire_rvalid & o_wire_rready;
  assign last_beat         = (count_q == beats_q - 9'd1);
  assign beat_bad          = (i_wire_rresp != AxiRespOkay) | (i_wire_rlast != last_beat);
  assign o_wire_fifo_wen   = (state_q == StData) & i_wire_run & r_hs & ~beat_bad;
  assign o_wire_fifo_wdata = o_wire_fifo_wen ? i_wire_rdata : 32'd0;

  assign o_wire_done    = done_q;
  assign o_wire_error   = error_q;
  assign o_wire_araddr  = araddr_q;
  assign o_wire_arlen   = arlen_q;
  assign o_wire_arvalid = arvalid_q;
  assign o_wire_state   = {29'd0, state_q};

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      length_q    <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      count_q     <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      drain_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_wire_run) begin
            addr_q      <= i_wire_address;
            length_q    <= i_wire_length;
            remaining_q <= i_wire_length[15:0];
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          if (!i_wire_run) begin
            state_q <= StIdle;
          end else if (length_q == 32'd0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (length_q > 32'(MAX_LENGTH) || addr_q[1:0] != 2'b00) begin
            state_q <= StError;
            error_q <= 1'b1;
          end else begin
            state_q   <= StAddr;
            arvalid_q <= 1'b1;
            araddr_q  <= addr_q;
            arlen_q   <= 8'(calc_beats - 9'd1);
            beats_q   <= calc_beats;
          end
        end
        StAddr: begin
          // arvalid stays up until accepted even when run drops
          if (i_wire_arready) begin
            arvalid_q   <= 1'b0;
            count_q     <= '0;
            drain_err_q <= 1'b0;
            state_q     <= i_wire_run ? StData : StDrain;
          end
        end
        StData: begin
          if (!i_wire_run) begin
            drain_err_q <= 1'b0;
            state_q     <= (r_hs && i_wire_rlast) ? StIdle : StDrain;
          end else if (r_hs) begin
            if (beat_bad) begin
              if (i_wire_rlast) begin
                state_q <= StError;
                error_q <= 1'b1;
              end else begin
                state_q     <= StDrain;
                drain_err_q <= 1'b1;
              end
            end else if (last_beat) begin
              remaining_q <= rem_after;
              addr_q      <= addr_after;
              if (rem_after == 16'd0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q   <= StAddr;
                arvalid_q <= 1'b1;
                araddr_q  <= addr_after;
                arlen_q   <= 8'(calc_beats - 9'd1);
                beats_q   <= calc_beats;
              end
            end else begin
              count_q <= count_q + 9'd1;
            end
          end
        end
        StDrain: begin
          if (i_wire_rvalid && i_wire_rlast) begin
            if (drain_err_q && i_wire_run) begin
              state_q <= StError;
              error_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDone: begin
          if (!i_wire_run) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        StError: begin
          if (!i_wire_run) begin
            state_q <= StIdle;
            error_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_block_reader.sv
// Bench for the block reader: AXI memory responder, reference burst/pixel model, per-cycle checker.
module tb_painterengine_gpu_block_reader;

  logic        clk = 1'b0;
  logic        rst, run, arready, rlast, rvalid, fifo_full;
  logic [31:0] address, length, rdata;
  logic [1:0]  rresp;
  logic        done, error, arvalid, rready, fifo_wen;
  logic [31:0] araddr, fifo_wdata, state;
  logic [7:0]  arlen;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model expectations and observations
  logic [31:0] exp_pix[$];
  logic [39:0] exp_ar[$];
  logic [39:0] ar_log[$];
  int          n_writes = 0;
  bit          want_done = 1'b0;
  bit          chk_done_next = 1'b0;

  // memory responder controls
  bit          ar_block = 1'b0;
  bit          full_mode = 1'b0;
  int          err_at = -1;
  int          cmd_beat = 0;
  int          sl_beat = 0;
  logic [31:0] sl_addr[$];
  logic [7:0]  sl_len[$];

  painterengine_gpu_block_reader #(
    .MAX_BURST (16),
    .MAX_LENGTH(64)
  ) dut (
    .i_wire_clock     (clk),
    .i_wire_reset     (rst),
    .i_wire_run       (run),
    .i_wire_address   (address),
    .i_wire_length    (length),
    .o_wire_done      (done),
    .o_wire_error     (error),
    .o_wire_araddr    (araddr),
    .o_wire_arlen     (arlen),
    .o_wire_arvalid   (arvalid),
    .i_wire_arready   (arready),
    .i_wire_rdata     (rdata),
    .i_wire_rresp     (rresp),
    .i_wire_rlast     (rlast),
    .i_wire_rvalid    (rvalid),
    .o_wire_rready    (rready),
    .o_wire_fifo_wdata(fifo_wdata),
    .o_wire_fifo_wen  (fifo_wen),
    .i_wire_fifo_full (fifo_full),
    .o_wire_state     (state)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pix(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI read responder: samples handshakes at negedge, updates its outputs just after posedge
  initial begin
    bit          ar_fire, r_fire;
    logic [31:0] a_now;
    logic [7:0]  l_now;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      a_now   = araddr;
      l_now   = arlen;
      @(posedge clk);
      #1;
      if (r_fire) begin
        cmd_beat++;
        if (sl_beat == int'(sl_len[0])) begin
          void'(sl_addr.pop_front());
          void'(sl_len.pop_front());
          sl_beat = 0;
        end else begin
          sl_beat++;
        end
      end
      if (ar_fire) begin
        sl_addr.push_back(a_now);
        sl_len.push_back(l_now);
      end
      arready   = !ar_block;
      fifo_full = full_mode && cyc[0];
      if (sl_addr.size() > 0) begin
        rvalid = 1'b1;
        rdata  = pix(sl_addr[0] + 32'(4 * sl_beat));
        rlast  = (sl_beat == int'(sl_len[0]));
        rresp  = (cmd_beat == err_at) ? 2'd2 : 2'd0;
      end else begin
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = '0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    bit          pv_valid, pv_ready;
    logic [31:0] pv_addr;
    pv_valid = 1'b0; pv_ready = 1'b0; pv_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chk_done_next) begin
          chk("done_latency", done, 1);
          chk_done_next = 1'b0;
        end
        if (fifo_wen) begin
          n_writes++;
          if (exp_pix.size() == 0) chk("spurious_fifo_wen", fifo_wen, 0);
          else begin
            chk("fifo_wdata", fifo_wdata, exp_pix.pop_front());
            if (exp_pix.size() == 0 && want_done) chk_done_next = 1'b1;
          end
        end
        chk("done_error_exclusive", done && error, 0);
        if (state == 32'd3) chk("rready_vs_full", rready, !fifo_full);
        if (pv_valid && !pv_ready) begin
          chk("arvalid_hold", arvalid, 1);
          chk("araddr_hold", araddr, pv_addr);
        end
        if (arvalid && arready) begin
          ar_log.push_back({araddr, arlen});
          if (exp_ar.size() == 0) chk("spurious_ar", arvalid, 0);
          else chk("ar_request", {araddr, arlen}, exp_ar.pop_front());
        end
        pv_valid = arvalid;
        pv_ready = arready;
        pv_addr  = araddr;
      end
    end
  end

  task automatic run_cmd(input string name, input logic [31:0] a, input logic [31:0] len,
                         input bit exp_done, input int exp_writes, input int st2);
    int rem, b, room, npix, rel, w0, budget;
    logic [31:0] cur;
    w0 = n_writes;
    if (len != 0 && len <= 64 && a[1:0] == 2'b00) begin
      rem = int'(len);
      cur = a;
      while (rem > 0) begin
        b    = (rem > 16) ? 16 : rem;
        room = (4096 - int'(cur[11:0])) / 4;
        if (b > room) b = room;
        exp_ar.push_back({cur, 8'(b - 1)});
        cur = cur + 32'(4 * b);
        rem = rem - b;
      end
      rel  = err_at - cmd_beat;
      npix = (err_at >= 0 && rel < int'(len)) ? rel : int'(len);
      for (int i = 0; i < npix; i++) exp_pix.push_back(pix(a + 32'(4 * i)));
    end
    want_done = exp_done;
    @(posedge clk);
    #1;
    address = a; length = len; run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_state_check"}, state, 1);
    @(negedge clk);
    chk({name, "_state_2cyc"}, state, 32'(st2));
    chk({name, "_arvalid_2cyc"}, arvalid, st2 == 2);
    for (budget = 0; budget < 3000 && !(done || error); budget++) @(negedge clk);
    chk({name, "_finished"}, done || error, 1);
    repeat (3) @(negedge clk);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, !exp_done);
    chk({name, "_writes"}, n_writes - w0, exp_writes);
    chk({name, "_pixels_left"}, exp_pix.size(), 0);
    chk({name, "_ars_left"}, exp_ar.size(), 0);
    @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_idle_state"}, state, 0);
    chk({name, "_flags_clear"}, {done, error}, 0);
  endtask

  initial begin
    int a0, w0, budget;
    logic [39:0] lit1[4];
    logic [39:0] lit2[2];
    lit1 = '{40'h00001000_0F, 40'h00001040_0F, 40'h00001080_0F, 40'h000010C0_0F};
    lit2 = '{40'h00001FF8_01, 40'h00002000_02};
    rst = 1'b1; run = 1'b0; address = '0; length = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_ar", {arvalid, araddr, arlen}, 0);
    chk("reset_flags", {done, error, rready, fifo_wen}, 0);
    chk("reset_wdata", fifo_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    a0 = ar_log.size();
    run_cmd("t1_len64", 32'h1000, 32'd64, 1'b1, 64, 2);
    chk("t1_ar_count", ar_log.size() - a0, 4);
    for (int i = 0; i < 4; i++) chk("t1_ar_literal", ar_log[a0 + i], lit1[i]);

    a0 = ar_log.size();
    run_cmd("t2_page_cross", 32'h1FF8, 32'd5, 1'b1, 5, 2);
    chk("t2_ar_count", ar_log.size() - a0, 2);
    for (int i = 0; i < 2; i++) chk("t2_ar_literal", ar_log[a0 + i], lit2[i]);

    full_mode = 1'b1;
    run_cmd("t3_fifo_full", 32'h3000, 32'd16, 1'b1, 16, 2);
    full_mode = 1'b0;

    a0 = ar_log.size();
    err_at = cmd_beat + 2;
    run_cmd("t4_rresp", 32'h4000, 32'd8, 1'b0, 2, 2);
    err_at = -1;
    chk("t4_ar_literal", ar_log[a0], 40'h00004000_07);

    // run dropped while the AR is stalled
    a0 = ar_log.size();
    w0 = n_writes;
    exp_ar.push_back({32'h5000, 8'd7});
    want_done = 1'b0;
    ar_block  = 1'b1;
    @(posedge clk);
    #1;
    address = 32'h5000; length = 32'd8; run = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_arvalid_up", arvalid, 1);
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_arvalid_held", {arvalid, araddr}, {1'b1, 32'h5000});
    chk("t5_state_addr", state, 2);
    @(posedge clk);
    #1;
    ar_block = 1'b0;
    @(negedge clk);
    for (budget = 0; budget < 200 && state != 32'd0; budget++) @(negedge clk);
    chk("t5_back_idle", state, 0);
    chk("t5_no_writes", n_writes - w0, 0);
    chk("t5_burst_drained", sl_addr.size(), 0);
    chk("t5_one_ar", ar_log.size() - a0, 1);
    chk("t5_flags", {done, error}, 0);

    run_cmd("t6_len0", 32'h6000, 32'd0, 1'b1, 0, 4);
    run_cmd("t7_len65", 32'h7000, 32'd65, 1'b0, 0, 5);
    run_cmd("t8_unaligned", 32'h1002, 32'd4, 1'b0, 0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
